// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one valid/ready pipeline register among R requesters.
// Winner's word is captured and presented downstream tagged with its index.
module reg_share_arbiter #(
  parameter int N   = 16,
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] data,
  output logic [R-1:0]   ack,
  output logic [N-1:0]   out,
  output logic [IDW-1:0] out_id,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [IDW-1:0] PTR_RST = IDW'(R-1);
  localparam logic [R-1:0]   ONE     = R'(1);

  logic [N-1:0]   out_q, out_d;
  logic [IDW-1:0] id_q, id_d;
  logic           vld_q, vld_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           space;
  logic           accept;
  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;

  // Scan ptr+1 .. ptr+R modulo R; first requester found wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= R; k++) begin
      cand = IDW'((int'(ptr_q) + k) % R);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign space  = !vld_q || out_ready;
  assign accept = rst_n && space && found && !clr;
  assign ack    = accept ? (ONE << win) : '0;

  always_comb begin
    out_d = out_q;
    id_d  = id_q;
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (clr) begin
      out_d = '0;
      id_d  = '0;
      vld_d = 1'b0;
      ptr_d = PTR_RST;
    end else if (accept) begin
      out_d = data[win*N +: N];
      id_d  = win;
      vld_d = 1'b1;
      ptr_d = win;
    end else if (space) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      id_q  <= '0;
      vld_q <= 1'b0;
      ptr_q <= PTR_RST;
    end else begin
      out_q <= out_d;
      id_q  <= id_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_id    = id_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed and random-soak bench for reg_share_arbiter (N=16, R=4).
// Scoreboard tracks accepted words through to delivery.
module tb_reg_share_arbiter;

  localparam int N   = 16;
  localparam int R   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clr;
  logic [R-1:0]   req;
  logic [R*N-1:0] data;
  logic [R-1:0]   ack;
  logic [N-1:0]   out;
  logic [IDW-1:0] out_id;
  logic           out_valid;
  logic           out_ready;

  int n_checks = 0;
  int n_errors = 0;

  reg_share_arbiter #(.N(N), .R(R), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .out       (out),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [N-1:0] w);
    data[i*N +: N] = w;
  endtask

  // Soak model state
  logic [IDW-1:0]     m_ptr;
  logic               m_valid;
  logic [N-1:0]       m_out;
  logic [IDW-1:0]     m_id;
  logic [R-1:0]       pend;
  logic [N-1:0]       word [R];
  int                 waits [R];
  logic [IDW+N-1:0]   sb [$];
  logic               m_space;
  logic               m_acc;
  logic [IDW-1:0]     m_w;
  logic [R-1:0]       e_ack;
  logic               hit;
  int                 c;

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;
    data      = '0;
    for (int i = 0; i < R; i++) set_word(i, 16'h1000 + 16'(i));

    // Reset holds everything quiet even with all requesting
    tick();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_vld", 32'(out_valid), 32'h0);
    check("rst_out", 32'(out), 32'h0);

    rst_n = 1'b1;
    #1;
    check("first_ack", 32'(ack), 32'h1);
    tick();
    check("first_id", 32'(out_id), 32'h0);
    check("first_out", 32'(out), 32'h1000);

    // Round-robin continues 1,2,3,0 with no bubbles
    for (int k = 1; k <= 4; k++) begin
      check("rr_ack", 32'(ack), 32'(1 << (k % 4)));
      tick();
      check("rr_vld", 32'(out_valid), 32'h1);
      check("rr_id", 32'(out_id), 32'(k % 4));
      check("rr_out", 32'(out), 32'h1000 + 32'(k % 4));
    end

    // Backpressure
    req = 4'b0100;
    set_word(2, 16'hBEEF);
    #1;
    check("bp_load_ack", 32'(ack), 32'h4);
    tick();
    check("bp_load_out", 32'(out), 32'hBEEF);
    out_ready = 1'b0;
    set_word(2, 16'hCAFE);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_stall_ack", 32'(ack), 32'h0);
      tick();
      check("bp_stall_out", 32'(out), 32'hBEEF);
      check("bp_stall_vld", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_ack", 32'(ack), 32'h4);
    tick();
    check("bp_rel_out", 32'(out), 32'hCAFE);
    check("bp_rel_id", 32'(out_id), 32'h2);

    // Sparse wrap from ptr=2
    req = 4'b0011;
    set_word(0, 16'hA0A0);
    set_word(1, 16'hA1A1);
    #1;
    check("wrap_ack0", 32'(ack), 32'h1);
    tick();
    check("wrap_out0", 32'(out), 32'hA0A0);
    check("wrap_ack1", 32'(ack), 32'h2);
    tick();
    check("wrap_out1", 32'(out), 32'hA1A1);
    check("wrap_id1", 32'(out_id), 32'h1);

    // Flush while full and ready; clr wins
    req = 4'b1000;
    set_word(3, 16'hD3D3);
    clr = 1'b1;
    #1;
    check("clr_ack", 32'(ack), 32'h0);
    tick();
    check("clr_vld", 32'(out_valid), 32'h0);
    check("clr_out", 32'(out), 32'h0);
    clr = 1'b0;
    req = 4'b1001;
    set_word(0, 16'h0E0E);
    #1;
    check("clr_ptr_ack", 32'(ack), 32'h1);
    tick();
    check("clr_next_id", 32'(out_id), 32'h0);
    check("clr_next_out", 32'(out), 32'h0E0E);

    // Idle cycle empties register but keeps out and ptr
    req = 4'b0000;
    #1;
    check("idle_ack", 32'(ack), 32'h0);
    tick();
    check("idle_vld", 32'(out_valid), 32'h0);
    check("idle_out", 32'(out), 32'h0E0E);
    req = 4'b1001;
    #1;
    check("idle_ptr_ack", 32'(ack), 32'h8);
    tick();
    check("idle_ptr_id", 32'(out_id), 32'h3);

    // Async reset between edges during streaming
    req = 4'b1111;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_vld", 32'(out_valid), 32'h0);
    check("async_out", 32'(out), 32'h0);
    check("async_ack", 32'(ack), 32'h0);
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rel_ack", 32'(ack), 32'h1);
    tick();
    check("async_rel_id", 32'(out_id), 32'h0);
    check("async_rel_out", 32'(out), 32'h0E0E);

    // Random soak against a reference model
    req   = '0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_ptr   = 2'(R - 1);
    m_valid = 1'b0;
    m_out   = '0;
    m_id    = '0;
    pend    = '0;
    for (int i = 0; i < R; i++) begin
      word[i]  = '0;
      waits[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < R; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          word[i] = 16'($urandom);
        end
        req[i] = pend[i];
        set_word(i, word[i]);
      end
      #1;
      m_space = !m_valid || out_ready;
      hit = 1'b0;
      m_w = '0;
      for (int k = 1; k <= R; k++) begin
        c = (int'(m_ptr) + k) % R;
        if (!hit && req[c]) begin
          hit = 1'b1;
          m_w = 2'(c);
        end
      end
      m_acc = m_space && hit && !clr;
      e_ack = m_acc ? (4'b0001 << m_w) : 4'b0000;
      check("soak_ack", 32'(ack), 32'(e_ack));
      check("soak_state", 32'({out_valid, out_id, out}),
            32'({m_valid, m_id, m_out}));
      if (clr) begin
        sb.delete();
        for (int i = 0; i < R; i++) waits[i] = 0;
      end else if (m_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("soak_sb_empty", 32'h0, 32'h1);
        end else begin
          check("soak_deliver", 32'({out_id, out}), 32'(sb[0]));
          void'(sb.pop_front());
        end
      end
      if (m_acc) begin
        sb.push_back({m_w, word[m_w]});
        check("soak_fair", 32'(waits[m_w] <= R - 1), 32'h1);
        waits[m_w] = 0;
        pend[m_w]  = 1'b0;
        for (int i = 0; i < R; i++)
          if (pend[i] && i != int'(m_w)) waits[i]++;
      end
      if (clr) begin
        m_valid = 1'b0;
        m_out   = '0;
        m_id    = '0;
        m_ptr   = 2'(R - 1);
      end else if (m_acc) begin
        m_valid = 1'b1;
        m_out   = word[m_w];
        m_id    = m_w;
        m_ptr   = m_w;
      end else if (m_space) begin
        m_valid = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
